// File: rtl/dma_ch_arbiter.sv
// DMA channel arbiter: round-robin grant with bounded bursts and a one-cycle gap.
// Define DMA_ARB_PRIORITY_EN to arbitrate on ch_pri first, round-robin on ties.
module dma_ch_arbiter #(
  parameter int CH_NUM      = 4,
  parameter int IDX_W       = $clog2(CH_NUM),
  parameter int BURST_BEATS = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [CH_NUM-1:0]     ch_req,
  input  logic [2*CH_NUM-1:0]   ch_pri,
  input  logic                  beat_ack,
  input  logic                  xfer_done,
  output logic [CH_NUM-1:0]     grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  grant_valid,
  output logic [7:0]            beat_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] scan;
  logic             found;
  logic             release_now;

`ifdef DMA_ARB_PRIORITY_EN
  logic [1:0] pri_a [CH_NUM];
  logic [1:0] best_pri;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_pri
    assign pri_a[k] = ch_pri[2*k +: 2];
  end
`else
  logic unused_pri;
  assign unused_pri = ^ch_pri;
`endif

  // Scan from last_idx+1; strict compare keeps the earliest tie.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    scan    = last_idx;
`ifdef DMA_ARB_PRIORITY_EN
    best_pri = '0;
`endif
    for (int i = 0; i < CH_NUM; i++) begin
      scan = (scan == IDX_W'(CH_NUM-1)) ? '0 : scan + IDX_W'(1);
`ifdef DMA_ARB_PRIORITY_EN
      if (ch_req[scan] && (!found || pri_a[scan] > best_pri)) begin
        found    = 1'b1;
        win_idx  = scan;
        best_pri = pri_a[scan];
      end
`else
      if (ch_req[scan] && !found) begin
        found   = 1'b1;
        win_idx = scan;
      end
`endif
    end
  end

  assign release_now = xfer_done ||
    (beat_ack && beat_cnt == 8'(BURST_BEATS-1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      beat_cnt    <= '0;
      last_idx    <= IDX_W'(CH_NUM-1);
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant       <= CH_NUM'(1) << win_idx;
            grant_idx   <= win_idx;
            grant_valid <= 1'b1;
            last_idx    <= win_idx;
            beat_cnt    <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (beat_ack) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
          if (release_now) begin
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            state       <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dma_ch_arbiter.md
# dma_ch_arbiter

Channel arbiter for the AHB DMA controller. Collects transfer requests from up to `CH_NUM` DMA channels and grants the bus engine to one channel at a time. It drives the select lines of the channel-data multiplexers directly upstream of the transfer engine. Grants are held for a bounded burst so that long transfers cannot starve other channels.

## Interface
- `CH_NUM`, 4: number of DMA channels; legal range is 2 to 16.
- `IDX_W`, `$clog2(CH_NUM)`: width of the channel index.
- `BURST_BEATS`, 4: maximum beats per grant; legal range is 1 to 255.
- `HCLK` in 1: the single block clock; everything is sampled on the rising edge.
- `HRESETn` in 1: asynchronous, active-low reset.
- `ch_req` in `CH_NUM`: per-channel request level.
- `ch_pri` in `2*CH_NUM`: 2-bit priority per channel; channel k uses bits `[2k+1:2k]`. Used only when the configuration macro is defined.
- `beat_ack` in 1: one-cycle pulse from the engine when one beat of the granted channel completes.
- `xfer_done` in 1: one-cycle pulse from the engine when the granted channel's whole transfer finishes.
- `grant` out `CH_NUM`: one-hot grant vector; all zero when nothing is granted.
- `grant_idx` out `IDX_W`: binary index of the granted channel; this is the mux select.
- `grant_valid` out 1: high while a grant is held.
- `beat_cnt` out 8: number of beats completed in the current grant.

## Operation
- **Reset values.** All outputs are registered.
  - `grant`=0, `grant_valid`=0, `grant_idx`=0, `beat_cnt`=0.
  - FSM state = IDLE.
  - Round-robin pointer `last_idx` = `CH_NUM-1`, so channel 0 wins the first tie.
- **FSM states:** IDLE, BUSY, GAP.
- **IDLE**
  - If `ch_req` is nonzero, compute the winner, register `grant`, `grant_idx`, `grant_valid`=1 and `last_idx`=winner, clear `beat_cnt`, then go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - Each `beat_ack` increments `beat_cnt`.
  - Release the grant on `xfer_done`, or on a `beat_ack` that brings `beat_cnt` to `BURST_BEATS`.
  - On release, go to GAP.
- **GAP**
  - Exactly one cycle with all grant outputs cleared and `beat_cnt` kept at its final value.
  - Then go to IDLE.
  - GAP guarantees the mux select never changes while `grant_valid` is high.
- **Winner selection (round-robin).** Scan indices `last_idx+1`, `last_idx+2`, … modulo `CH_NUM`; the first requesting channel wins.
- **Held grant.**
  - Deasserting `ch_req` of the granted channel during BUSY does not release the grant; only the engine releases it.
  - `ch_req` changes on other channels during BUSY are ignored.
- **Simultaneous events and ignored pulses.**
  - `xfer_done` and `beat_ack` in the same cycle: `beat_cnt` increments and the grant releases once.
  - `beat_ack` or `xfer_done` in IDLE or GAP is ignored.
- **Counter.** `beat_cnt` never exceeds `BURST_BEATS` and never wraps.
- **Reset during BUSY.** Asserting `HRESETn` low forces reset values immediately, independent of `HCLK`. No release pulse is produced.

## Timing
- **Grant latency.** A request sampled at edge N while in IDLE gives `grant_valid`=1 after edge N. That is one cycle from request to grant.
- **Release.** A `beat_ack` or `xfer_done` causing release, sampled at edge M, drops `grant_valid` after edge M.
- **Re-arbitration.** The next grant appears after edge M+2 at the earliest: the GAP cycle, then the IDLE arbitration.
- **Output stability.** `grant`, `grant_idx` and `grant_valid` change only at state transitions and are constant throughout BUSY.
- **Throughput.** One grant per `BURST_BEATS`+2 cycles minimum when beats are back-to-back.

## Configuration
- **`DMA_ARB_PRIORITY_EN` defined**
  - The winner is the requesting channel with the highest `ch_pri` value.
  - Ties among equal highest priority are broken round-robin from `last_idx+1`.
  - `last_idx` is updated to the winner.
- **`DMA_ARB_PRIORITY_EN` undefined**
  - `ch_pri` is ignored and the port remains present.
  - Arbitration is pure round-robin as described in Operation.

## Test plan
- **Reset, then single request.** Reset, then `ch_req`=4'b0100. Expect `grant`=4'b0100, `grant_idx`=2 and `grant_valid`=1 one cycle later. After 4 `beat_ack` pulses, expect `grant_valid`=0 with `beat_cnt`=4, then 1 GAP cycle.
- **Round-robin order.** Hold `ch_req`=4'b1111 with continuous `beat_ack`. Expect grants to channels 0, 1, 2, 3, 0, with exactly one idle cycle plus one GAP cycle between grants.
- **Early done.** Channel 1 is granted. After 2 beats, pulse `xfer_done` together with `beat_ack`. Expect release that cycle, `beat_cnt`=3 and no double release.
- **Request withdrawal and stray pulses.**
  - Channel 3 is granted and drops `ch_req` mid-burst: the grant is held until the 4th `beat_ack`.
  - A `beat_ack` pulsed in IDLE leaves `beat_cnt` unchanged.
- **Priority, macro defined.** `ch_req`=4'b1011 with priorities ch0=1, ch1=3, ch3=3. Expect ch1 granted, then ch3, then ch1 (tie round-robin); ch0 is not granted while ch1 and ch3 keep requesting.
- **Reset mid-burst.** Channel 2 is granted with `beat_cnt`=2. Assert `HRESETn` low between clock edges. Expect all outputs to go to 0 asynchronously, and the next request of `ch_req`=4'b0101 to grant channel 0.
